// File: rtl/serial_inv_theta_key.sv
// ----------------------------------------------------------------------------
// serial_inv_theta_key
// Serial inverse of the SWAN64 theta/round-key layer (decryption datapath).
// One half-state word x and its round key rk are accepted over a valid/ready
// handshake, then processed one column per clock: v = x_col ^ rk_col,
// y_col = rotl(v, P). Column 3 is not rotated.
//
// Optional build macro SWAN_INV_THETA_FWD_EN adds a 'mode' input sampled at
// the accepting edge: mode=1 selects the forward theta-key
// (y_col = rotr(x_col, P) ^ rk_col); mode=0 is the inverse above.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   x/rk presented
//   in_ready   block can accept (registered)
//   x, rk      state half / round key, [0:SIDE_SIZE-1], bit 0 = MSB
//   mode       (SWAN_INV_THETA_FWD_EN only) 0 = inverse, 1 = forward
//   out_valid  y holds a result (registered)
//   out_ready  consumer takes y
//   y          result, [0:SIDE_SIZE-1]
// ----------------------------------------------------------------------------
module serial_inv_theta_key #(
    parameter int unsigned BLOCK_SIZE  = 64,
    parameter int unsigned SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int unsigned COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int unsigned PA          = 1,
    parameter int unsigned PB          = 2,
    parameter int unsigned PC          = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:SIDE_SIZE-1]   x,
    input  logic [0:SIDE_SIZE-1]   rk,
`ifdef SWAN_INV_THETA_FWD_EN
    input  logic                   mode,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:SIDE_SIZE-1]   y
);

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned CNT_W    = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [0:SIDE_SIZE-1]   x_q, x_d;
    logic [0:SIDE_SIZE-1]   rk_q, rk_d;
    logic [0:SIDE_SIZE-1]   y_q, y_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   mode_q, mode_d;
    logic                   mode_in;

    logic [COLUMN_SIZE-1:0] col_x;
    logic [COLUMN_SIZE-1:0] col_rk;
    logic [COLUMN_SIZE-1:0] col_res;
    int unsigned            rot;

`ifdef SWAN_INV_THETA_FWD_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif

    function automatic logic [COLUMN_SIZE-1:0] rotl(input logic [COLUMN_SIZE-1:0] v,
                                                    input int unsigned p);
        return (v << p) | (v >> (COLUMN_SIZE - p));
    endfunction

    function automatic logic [COLUMN_SIZE-1:0] rotr(input logic [COLUMN_SIZE-1:0] v,
                                                    input int unsigned p);
        return (v >> p) | (v << (COLUMN_SIZE - p));
    endfunction

    // Column datapath: select column cnt of the captured words and transform it
    always_comb begin
        col_x  = '0;
        col_rk = '0;
        for (int k = 0; k < int'(NUM_COLS); k++) begin
            if (cnt_q == CNT_W'(k)) begin
                col_x  = x_q[k*COLUMN_SIZE +: COLUMN_SIZE];
                col_rk = rk_q[k*COLUMN_SIZE +: COLUMN_SIZE];
            end
        end
        case (cnt_q)
            2'd0:    rot = PC;
            2'd1:    rot = PB;
            2'd2:    rot = PA;
            default: rot = 0;
        endcase
        if (mode_q) begin
            // forward: rotate first, then key
            col_res = ((cnt_q == 2'd3) ? col_x : rotr(col_x, rot)) ^ col_rk;
        end else begin
            // inverse: key first, then undo the rotate right
            col_res = (cnt_q == 2'd3) ? (col_x ^ col_rk) : rotl(col_x ^ col_rk, rot);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            rk_q        <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            rk_q        <= rk_d;
            y_q         <= y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
        end
    end

    // Next-state logic; handshake outputs are computed one cycle ahead
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        rk_d        = rk_q;
        y_d         = y_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        mode_d      = mode_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = S_BUSY;
                    x_d        = x;
                    rk_d       = rk;
                    mode_d     = mode_in;
                    cnt_d      = '0;
                    y_d        = '0;
                    in_ready_d = 1'b0;
                end
            end
            S_BUSY: begin
                for (int k = 0; k < int'(NUM_COLS); k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        y_d[k*COLUMN_SIZE +: COLUMN_SIZE] = col_res;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == 2'd3) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_serial_inv_theta_key.sv
// ----------------------------------------------------------------------------
// tb_serial_inv_theta_key
// Directed and model-checked bench for serial_inv_theta_key (default
// parameters, 32-bit half-state, 8-bit columns). Forward-mode round trip is
// exercised when SWAN_INV_THETA_FWD_EN is defined.
// ----------------------------------------------------------------------------
module tb_serial_inv_theta_key;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] rk;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        mode_r;

    int checks   = 0;
    int failures = 0;

    serial_inv_theta_key dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .rk        (rk),
`ifdef SWAN_INV_THETA_FWD_EN
        .mode      (mode_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bit-level reference, MSB-first indexing within each column
    function automatic logic [31:0] model(input logic [31:0] xv, input logic [31:0] rkv,
                                          input logic fwd);
        logic [0:31] xa;
        logic [0:31] ra;
        logic [0:31] ya;
        int          p;
        xa = xv;
        ra = rkv;
        for (int k = 0; k < 4; k++) begin
            p = (k == 0) ? 7 : (k == 1) ? 2 : (k == 2) ? 1 : 0;
            for (int j = 0; j < 8; j++) begin
                if (fwd)
                    ya[k*8+j] = xa[k*8 + ((j - p + 8) % 8)] ^ ra[k*8+j];
                else
                    ya[k*8+j] = xa[k*8 + ((j + p) % 8)] ^ ra[k*8 + ((j + p) % 8)];
            end
        end
        return ya;
    endfunction

    // One word with out_ready held high: checks latency, result, return to idle
    task automatic run_word(input string tag, input logic [31:0] xv, input logic [31:0] rkv,
                            input logic [31:0] exp, output logic [31:0] got);
        int lat;
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        x         = xv;
        rk        = rkv;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = ~xv;
        rk       = ~rkv;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_y"}, y, exp);
        got = y;
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    logic [31:0] r;
    logic [31:0] xv, rkv, y1;
    int          w;
    logic        seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        rk        = '0;
        mode_r    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'h0);

        // Directed hand-computed vectors
        run_word("v1", 32'h01020480, 32'h00000000, 32'h80080880, r);
        run_word("v2", 32'h00000000, 32'h12345678, 32'h09D0AC78, r);
        run_word("v3", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, r);
        run_word("v4", 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, r);

        // Backpressure: out_ready low, in_valid high with x changing
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 32'h01020480;
        rk        = 32'h00000000;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        w = 0;
        while (!out_valid && w < 20) begin
            x = $urandom;
            @(posedge clk);
            #1;
            w++;
        end
        check("bp_latency", 32'(w), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            x = $urandom;
            check("bp_y", y, 32'h80080880);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("bp_no_second", 32'(seen), 32'd0);

        // Reset while cnt==2
        @(negedge clk);
        in_valid = 1'b1;
        x        = 32'h12345678;
        rk       = 32'h0F0F0F0F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", y, 32'h0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("mid_rst_no_valid", 32'(seen), 32'd0);
        run_word("after_rst", 32'h01020480, 32'h12345678, 32'h89D8A4F8, r);

        // Random words against the reference model
        for (int i = 0; i < 1000; i++) begin
            xv  = $urandom;
            rkv = $urandom;
            run_word("rand", xv, rkv, model(xv, rkv, 1'b0), r);
        end

`ifdef SWAN_INV_THETA_FWD_EN
        // Forward then inverse with the same key recovers x
        for (int i = 0; i < 20; i++) begin
            xv     = $urandom;
            rkv    = $urandom;
            mode_r = 1'b1;
            run_word("fwd", xv, rkv, model(xv, rkv, 1'b1), y1);
            mode_r = 1'b0;
            run_word("roundtrip", y1, rkv, xv, r);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
